// File: rtl/grf_sb_pkg.sv
// Shared defaults and the scoreboard next-state function for the grf_sb register file.
package grf_pkg;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_AW      = 5;
  localparam int unsigned DEF_SP_IDX  = 29;
  localparam logic [31:0] DEF_SP_INIT = 32'h00002ffc;

  // Scoreboard vector is sized for the widest supported address space.
  localparam int unsigned SB_AW   = 5;
  localparam int unsigned SB_MAXW = 2**SB_AW;

  // Clear-on-write is applied before set-on-issue so a same-edge issue keeps the bit set.
  function automatic logic [SB_MAXW-1:0] sb_next(
    input logic [SB_MAXW-1:0] sb,
    input logic               iss_we,
    input logic [SB_AW-1:0]   iss_wa,
    input logic               we,
    input logic [SB_AW-1:0]   wa,
    input logic               flush
  );
    logic [SB_MAXW-1:0] nx;
    nx = sb;
    if (flush) begin
      nx = '0;
    end else begin
      if (we && (wa != '0))         nx[wa]     = 1'b0;
      if (iss_we && (iss_wa != '0)) nx[iss_wa] = 1'b1;
    end
    return nx;
  endfunction
endpackage

// File: rtl/grf_sb_if.sv
// Bus bundle between the ID/WB stages (master) and the grf_sb register file (slave).
interface grf_sb_if
  import grf_pkg::*;
#(
    parameter int unsigned DW  = DEF_DW,
    parameter int unsigned AW  = DEF_AW,
    parameter int unsigned NRD = 2
);
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    rbusy;
    logic              we;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic [31:0]       wpc;
    logic              iss_we;
    logic [AW-1:0]     iss_wa;
    logic              flush;
    logic              wlog_valid;
    logic [31:0]       wlog_pc;
    logic [AW-1:0]     wlog_addr;
    logic [DW-1:0]     wlog_data;

    modport master (
        output ra, we, wa, wd, wpc, iss_we, iss_wa, flush,
        input  rd, rbusy, wlog_valid, wlog_pc, wlog_addr, wlog_data
    );

    modport slave (
        input  ra, we, wa, wd, wpc, iss_we, iss_wa, flush,
        output rd, rbusy, wlog_valid, wlog_pc, wlog_addr, wlog_data
    );
endinterface

// File: rtl/grf_sb_rdport.sv
// One read port: register-0 zeroing, optional write-to-read bypass and busy qualification.
module grf_sb_rdport
  import grf_pkg::*;
#(
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned BYPASS = 1
) (
    input  logic [AW-1:0] i_ra,
    input  logic [DW-1:0] i_rdata,
    input  logic          i_sb,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [DW-1:0] i_wd,
    output logic [DW-1:0] o_rd,
    output logic          o_busy
);
    logic w_hit;

    always_comb begin
        w_hit  = (BYPASS != 0) && i_we && (i_wa == i_ra);
        o_rd   = '0;
        o_busy = 1'b0;
        if (i_ra != '0) begin
            o_rd   = w_hit ? i_wd : i_rdata;
            o_busy = i_sb && !w_hit;
        end
    end
endmodule

// File: rtl/grf_sb.sv
// General register file with N read ports, pending-write scoreboard and registered write log.
module grf_sb
  import grf_pkg::*;
#(
    parameter int unsigned       DW      = DEF_DW,
    parameter int unsigned       AW      = DEF_AW,
    parameter int unsigned       NRD     = 2,
    parameter int unsigned       SP_IDX  = DEF_SP_IDX,
    parameter logic [DW-1:0]     SP_INIT = DW'(DEF_SP_INIT),
    parameter int unsigned       BYPASS  = 1
) (
    input logic      clk,
    input logic      reset,
    grf_sb_if.slave  bus
);
    localparam int unsigned DEPTH = 2**AW;

    logic [DW-1:0]      r_mem [DEPTH];
    logic [DEPTH-1:0]   r_sb;
    logic [SB_MAXW-1:0] w_sb_nx;
    logic               w_wr;

    logic               r_wlog_valid;
    logic [31:0]        r_wlog_pc;
    logic [AW-1:0]      r_wlog_addr;
    logic [DW-1:0]      r_wlog_data;

    assign w_wr = bus.we && (bus.wa != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_mem[AW'(i)] <= (i == SP_IDX) ? SP_INIT : '0;
        end else if (w_wr) begin
            r_mem[bus.wa] <= bus.wd;
        end
    end

    assign w_sb_nx = sb_next(SB_MAXW'(r_sb), bus.iss_we, SB_AW'(bus.iss_wa),
                             bus.we, SB_AW'(bus.wa), bus.flush);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sb <= '0;
        else       r_sb <= w_sb_nx[DEPTH-1:0];
    end

    // Log fields hold between commits; only the strobe is pulsed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wlog_valid <= 1'b0;
            r_wlog_pc    <= '0;
            r_wlog_addr  <= '0;
            r_wlog_data  <= '0;
        end else begin
            r_wlog_valid <= w_wr;
            if (w_wr) begin
                r_wlog_pc   <= bus.wpc;
                r_wlog_addr <= bus.wa;
                r_wlog_data <= bus.wd;
            end
        end
    end

    assign bus.wlog_valid = r_wlog_valid;
    assign bus.wlog_pc    = r_wlog_pc;
    assign bus.wlog_addr  = r_wlog_addr;
    assign bus.wlog_data  = r_wlog_data;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = bus.ra[k*AW +: AW];

        grf_sb_rdport #(
            .DW     (DW),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rdport (
            .i_ra    (w_ra),
            .i_rdata (r_mem[w_ra]),
            .i_sb    (r_sb[w_ra]),
            .i_we    (bus.we),
            .i_wa    (bus.wa),
            .i_wd    (bus.wd),
            .o_rd    (bus.rd[k*DW +: DW]),
            .o_busy  (bus.rbusy[k])
        );
    end
endmodule

// File: doc/grf_sb.md
Name: grf_sb

Overview:
- Parametrised successor to the single-write, two-read general register file of the pipelined MIPS core.
- Adds N read ports with optional write-to-read bypass, a per-register pending-write scoreboard that drives read-port stall flags, and a registered write-log port that replaces in-RTL display output.
- Sits in the ID stage: read ports feed the operand muxes, the write port comes from WB, and scoreboard issue comes from the ID/EX handoff.

Parameters:
- DW, 32, data width.
- AW, 5, address width; depth = 2**AW.
- NRD, 2, number of read ports (1..4).
- SP_IDX, 29, index of stack-pointer register.
- SP_INIT, 32'h00002ffc, reset value of register SP_IDX.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = no forwarding.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ra  in  NRD*AW  read addresses; port k = ra[k*AW +: AW].
- rd  out  NRD*DW  read data; port k = rd[k*DW +: DW].
- rbusy  out  NRD  port k address has a pending write (scoreboard bit set).
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  DW  write data.
- wpc  in  32  PC of writing instruction (log only).
- iss_we  in  1  instruction issued that will write iss_wa.
- iss_wa  in  AW  destination of issued instruction.
- flush  in  1  clear all scoreboard bits (pipeline flush).
- wlog_valid  out  1  write-log strobe.
- wlog_pc  out  32  logged PC.
- wlog_addr  out  AW  logged register.
- wlog_data  out  DW  logged data.

Behaviour:
- Reset (async, active-high, immediate):
  - All registers 0, except register SP_IDX = SP_INIT.
  - All scoreboard bits 0.
  - wlog_valid/pc/addr/data all 0.
- Register 0:
  - Always reads 0.
  - Writes to address 0 are ignored and produce no log entry.
  - Issue to address 0 never sets a scoreboard bit.
- Write: on the clk edge with we=1 and wa!=0, reg[wa] <= wd.
- Read (combinational):
  - rd[k] = 0 if ra[k]=0.
  - Else, if BYPASS=1, we=1 and wa=ra[k]: rd[k] = wd.
  - Else rd[k] = reg[ra[k]].
  - BYPASS=0: rd[k] shows the new value only the cycle after the write edge.
- Scoreboard, per register r!=0, at each clk edge (first matching rule wins):
  - flush=1 -> clear all bits; flush overrides simultaneous issue.
  - iss_we=1 and iss_wa=r -> set bit. A same-edge write to r still updates the data; the bit stays set because the newer instruction is pending.
  - we=1 and wa=r -> clear bit.
- rbusy[k]:
  - rbusy[k] = sb[ra[k]] & ~(BYPASS & we & (wa==ra[k])).
  - A write landing this cycle satisfies the read when bypass is on.
  - ra[k]=0 -> rbusy[k]=0.
- Write log:
  - Registered, 1-cycle latency. On the edge where a non-zero write commits: wlog_valid<=1, wlog_pc<=wpc, wlog_addr<=wa, wlog_data<=wd.
  - Otherwise wlog_valid<=0; other log fields hold.
- Reset asserted mid-operation:
  - The pending write is discarded.
  - The scoreboard clears.
  - The log strobe drops asynchronously.
- Multiple read ports may address the same register; all return identical data and busy.

Decomposition:
- Package grf_pkg holds:
  - Localparams for default DW/AW/SP_IDX/SP_INIT.
  - Function sb_next(sb, iss_we, iss_wa, we, wa, flush) returning the next scoreboard vector.
- One natural sub-module, grf_sb_rdport: the single-port read mux with zero-check, bypass and busy. It is instantiated NRD times in a generate loop.
- Storage, scoreboard and log stay in the top module.

Test Plan:
- Reset: assert reset mid-cycle, no clock edge -> every read 0 except ra=29 gives 32'h00002ffc; rbusy=0; wlog_valid=0.
- Write/log: we=1, wa=8, wd=32'hdeadbeef, wpc=32'h00003000 -> next cycle ra0=8 reads deadbeef; wlog_valid=1 for one cycle with pc=3000, addr=8, data=deadbeef. Then wa=0, wd=1 -> ra0=0 reads 0 and wlog_valid stays 0.
- Bypass: BYPASS=1, same cycle we=1, wa=5, wd=32'h12345678, ra1=5 -> rd1=12345678 combinationally. Rebuild with BYPASS=0 -> rd1 shows the old value until after the edge.
- Scoreboard: iss_we=1, iss_wa=9 -> next cycle ra0=9 gives rbusy0=1; later we=1, wa=9 -> rbusy0=0 in that same cycle (bypass); after the edge the bit stays cleared.
- Simultaneous events: at one edge iss_wa=9 and wa=9 -> bit remains set, data updated. At one edge flush=1 and iss_wa=10 -> all bits clear, including 10.
- NRD=4: four ports read 0, 29, 8 and 8 concurrently -> values 0, 2ffc, last written, last written; busy flags consistent across the duplicated ports.
